// File: rtl/inject_queue_pkg.sv
// Shared constants and helpers for the host-side injection queue feeding router input port 0.
// Field layout of one buffer word is {Full, Vc, flit}, flit carrying the Tail flag in its MSB.
package inject_queue_pkg;

    localparam int MAX_VC          = 4;
    localparam int BUFFER_BIT_SIZE = 22;
    localparam int INJ_DEPTH       = 8;
    localparam int OP_SIZE         = 3;

    localparam int VC_W      = 3;
    localparam int FLIT_W    = 18;
    localparam int BUF_FULL  = 21;
    localparam int VC_LSB    = 18;
    localparam int FLIT_TAIL = 17;

    typedef enum logic [OP_SIZE-1:0] {
        OP_NOP          = 3'd0,
        OP_INIT         = 3'd1,
        OP_PHASE1       = 3'd2,
        OP_PHASE2       = 3'd3,
        OP_LOAD_STAGING = 3'd4
    } op_e;

    function automatic logic [BUFFER_BIT_SIZE-1:0] make_word(
        input logic [VC_W-1:0]   vc,
        input logic [FLIT_W-1:0] flit
    );
        return {1'b1, vc, flit};
    endfunction

endpackage

// File: rtl/inject_queue_if.sv
// Source-side write handshake and router-side staging/credit signals of the injection queue.
interface inject_queue_if #(
    parameter int MAXVC = 4,
    parameter int BUF_W = 22
);
    logic             wr_valid;
    logic [BUF_W-1:0] wr_data;
    logic [MAXVC-1:0] wr_ready;
    logic [MAXVC-1:0] can_inject;
    logic [BUF_W-1:0] stage_out;

    modport master (
        output wr_valid,
        output wr_data,
        output can_inject,
        input  wr_ready,
        input  stage_out
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  can_inject,
        output wr_ready,
        output stage_out
    );
endinterface

// File: rtl/inject_queue_vc_fifo.sv
// Single-VC flit FIFO with combinational head; storage is not reset, only pointers and count.
module vc_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/inject_queue.sv
// Injection stage upstream of router input port 0: per-VC FIFOs, round-robin issue gated by
// can_inject, and a one-cycle stage register driving slot 0 of the router's staging bus.
module inject_queue
    import inject_queue_pkg::*;
#(
    parameter int MAXVC = MAX_VC,
    parameter int DEPTH = INJ_DEPTH,
    parameter int BUF_W = BUFFER_BIT_SIZE,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_SIZE-1:0] op,
    inject_queue_if.slave      bus,
    output logic [CNT_W-1:0]   inj_count,
    output logic               idle,
    output logic               err
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_full_bit;
    logic [VC_W-1:0]   wr_vc;
    logic [FLIT_W-1:0] wr_flit;
    logic              wr_bad;

    logic [MAXVC-1:0]  push;
    logic [MAXVC-1:0]  pop;
    logic [MAXVC-1:0]  full;
    logic [MAXVC-1:0]  empty;
    logic [MAXVC-1:0]  elig;
    logic [FLIT_W-1:0] head  [MAXVC];
    logic [CW-1:0]     count [MAXVC];

    logic              is_load;
    logic              found;
    logic [MAXVC-1:0]  win_oh;
    logic [VC_W-1:0]   win_vc;
    logic [FLIT_W-1:0] win_flit;
    logic [VC_W-1:0]   rr;
    logic [VC_W-1:0]   rr_nxt;
    logic [BUF_W-1:0]  stage_p0;

    assign wr_full_bit = bus.wr_data[BUF_FULL];
    assign wr_vc       = bus.wr_data[VC_LSB +: VC_W];
    assign wr_flit     = bus.wr_data[FLIT_W-1:0];
    assign wr_bad      = bus.wr_valid && wr_full_bit && (int'(wr_vc) >= MAXVC);
    assign is_load     = (op == OP_LOAD_STAGING);

    for (genvar v = 0; v < MAXVC; v++) begin : g_vc
        assign push[v] = bus.wr_valid && wr_full_bit && (int'(wr_vc) == v) && !full[v];

        vc_fifo #(
            .W     (FLIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   (wr_flit),
            .dout  (head[v]),
            .count (count[v]),
            .full  (full[v]),
            .empty (empty[v])
        );
    end

    // wr_ready comes from registered state only, so a full FIFO refuses a write on a popping edge.
    assign bus.wr_ready = ~full;
    assign elig         = ~empty & bus.can_inject;
    assign pop          = (is_load && found) ? win_oh : '0;

    // Round-robin search starting at rr; offset loop outside, VC loop inside keeps indices constant.
    always_comb begin
        found    = 1'b0;
        win_oh   = '0;
        win_vc   = '0;
        win_flit = '0;
        rr_nxt   = rr;
        for (int i = 0; i < MAXVC; i++) begin
            for (int v = 0; v < MAXVC; v++) begin
                if (!found && elig[v] && (v == (int'(rr) + i) % MAXVC)) begin
                    found     = 1'b1;
                    win_oh[v] = 1'b1;
                    win_vc    = VC_W'(v);
                    win_flit  = head[v];
                    rr_nxt    = (v == MAXVC - 1) ? '0 : VC_W'(v + 1);
                end
            end
        end
    end

    always_comb begin
        idle = !stage_p0[BUF_FULL];
        for (int v = 0; v < MAXVC; v++) begin
            if (count[v] != '0) begin
                idle = 1'b0;
            end
        end
    end

    // ---- stage p0: staging register, counters, sticky error ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_p0  <= '0;
            inj_count <= '0;
            err       <= 1'b0;
            rr        <= '0;
        end else begin
            if (wr_bad) begin
                err <= 1'b1;
            end
            if (is_load && found) begin
                stage_p0  <= make_word(win_vc, win_flit);
                inj_count <= inj_count + CNT_W'(1);
                rr        <= rr_nxt;
            end else begin
                stage_p0  <= '0;
            end
        end
    end

    assign bus.stage_out = stage_p0;

endmodule

// File: tb/tb_inject_queue.sv
// Scoreboard bench for inject_queue: a per-VC queue model predicts each staging word.
module tb_inject_queue;
    import inject_queue_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [OP_SIZE-1:0] op;
    logic [15:0]        inj_count;
    logic               idle;
    logic               err;
    logic [3:0]         ci;

    inject_queue_if #(.MAXVC(4), .BUF_W(22)) bus ();

    inject_queue #(
        .MAXVC (4),
        .DEPTH (8),
        .BUF_W (22),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .bus       (bus),
        .inj_count (inj_count),
        .idle      (idle),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [21:0] exp_q [$];
    logic [21:0] last_stage;

    logic [17:0] mbuf [4][8];
    int          mrd  [4];
    int          mwr  [4];
    int          mn   [4];
    int          mrr;
    int          minj;
    logic        merr;
    int          seq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            mrd[v] = 0;
            mwr[v] = 0;
            mn[v]  = 0;
        end
        mrr  = 0;
        minj = 0;
        merr = 1'b0;
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        for (int v = 0; v < 4; v++) r[v] = (mn[v] != 8);
        return r;
    endfunction

    function automatic logic model_idle(input logic [21:0] stage);
        logic e;
        e = !stage[21];
        for (int v = 0; v < 4; v++) if (mn[v] != 0) e = 1'b0;
        return e;
    endfunction

    // One clock: drive, predict, advance, compare against the scoreboard.
    task automatic step(input logic [2:0] o, input logic wv, input logic [21:0] wd);
        logic [21:0] ew;
        logic        acc;
        bit          found;
        int          wvc;
        int          v;
        op             = o;
        bus.wr_valid   = wv;
        bus.wr_data    = wd;
        bus.can_inject = ci;
        wvc = int'(wd[20:18]);
        acc = 1'b0;
        if (wv && wd[21]) begin
            if (wvc >= 4) merr = 1'b1;
            else acc = (mn[wvc] != 8);
        end
        ew    = '0;
        found = 0;
        if (o == OP_LOAD_STAGING) begin
            for (int i = 0; i < 4; i++) begin
                v = (mrr + i) % 4;
                if (!found && mn[v] > 0 && ci[v]) begin
                    found  = 1;
                    ew     = {1'b1, 3'(v), mbuf[v][mrd[v]]};
                    mrd[v] = (mrd[v] + 1) % 8;
                    mn[v]  = mn[v] - 1;
                    mrr    = (v + 1) % 4;
                    minj   = minj + 1;
                end
            end
        end
        if (acc) begin
            mbuf[wvc][mwr[wvc]] = wd[17:0];
            mwr[wvc] = (mwr[wvc] + 1) % 8;
            mn[wvc]  = mn[wvc] + 1;
        end
        exp_q.push_back(ew);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        op           = OP_NOP;
        last_stage   = bus.stage_out;
        check_eq("stage_out", bus.stage_out, exp_q.pop_front());
        check_eq("inj_count", inj_count, minj[15:0]);
        check_eq("err", err, merr);
        check_eq("wr_ready", bus.wr_ready, model_ready());
        check_eq("idle", idle, model_idle(ew));
    endtask

    task automatic wr(input int vc, input logic tail);
        seq++;
        step(OP_NOP, 1'b1, {1'b1, 3'(vc), tail, 17'(seq)});
    endtask

    task automatic load();
        step(OP_LOAD_STAGING, 1'b0, '0);
    endtask

    initial begin
        op             = OP_NOP;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.can_inject = '0;
        ci             = 4'b1111;
        seq            = 0;
        last_stage     = '0;
        model_reset();

        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_stage", bus.stage_out, 0);
        check_eq("rst_inj", inj_count, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", bus.wr_ready, 4'hf);
        check_eq("rst_idle", idle, 1);
        rst_n = 1'b1;

        // Two VCs from a fresh round-robin pointer: VC0 then VC2.
        wr(0, 1'b1);
        wr(2, 1'b1);
        load();
        check_eq("rr_first_vc", last_stage[20:18], 0);
        load();
        check_eq("rr_second_vc", last_stage[20:18], 2);
        step(OP_NOP, 1'b0, '0);

        // Three-flit packet on VC1 drains in order.
        wr(1, 1'b0);
        wr(1, 1'b0);
        wr(1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            load();
            check_eq("vc1_full", last_stage[21], 1);
            check_eq("vc1_vc", last_stage[20:18], 1);
        end
        check_eq("vc1_tail", last_stage[17], 1);
        step(OP_NOP, 1'b0, '0);
        check_eq("vc1_inj", inj_count, 5);
        check_eq("vc1_idle", idle, 1);

        // Blocked VC0 holds its flits until can_inject returns.
        wr(0, 1'b0);
        wr(0, 1'b1);
        ci = 4'b1110;
        load();
        check_eq("blocked_stage", last_stage, 0);
        check_eq("blocked_idle", idle, 0);
        ci = 4'b1111;
        load();
        check_eq("unblock_vc", last_stage[20:18], 0);

        // Fill VC3, then a write on the popping edge must still be refused.
        for (int i = 0; i < 8; i++) wr(3, i == 7);
        check_eq("full_ready3", bus.wr_ready[3], 0);
        wr(3, 1'b0);
        seq++;
        step(OP_LOAD_STAGING, 1'b1, {1'b1, 3'd3, 1'b0, 17'(seq)});
        check_eq("pop_vc3", last_stage[20:18], 3);
        check_eq("ready3_after_pop", bus.wr_ready[3], 1);
        for (int i = 0; i < 40 && !model_idle(last_stage); i++) load();
        step(OP_NOP, 1'b0, '0);
        check_eq("drain_idle", idle, 1);

        // Out-of-range VC is dropped and the error is sticky.
        step(OP_NOP, 1'b1, {1'b1, 3'd5, 18'h1234});
        check_eq("bad_vc_err", err, 1);
        check_eq("bad_vc_idle", idle, 1);
        step(OP_NOP, 1'b0, '0);
        load();
        check_eq("err_sticky", err, 1);

        // Asynchronous reset mid-cycle discards queued flits.
        for (int v = 0; v < 4; v++) wr(v, 1'b1);
        load();
        check_eq("pre_rst_full", last_stage[21], 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_stage", bus.stage_out, 0);
        check_eq("async_inj", inj_count, 0);
        check_eq("async_err", err, 0);
        check_eq("async_idle", idle, 1);
        check_eq("async_ready", bus.wr_ready, 4'hf);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) load();
        check_eq("post_rst_inj", inj_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/inject_queue.md
Name: inject_queue

Overview:
- Host-side injection stage that sits directly upstream of router input port 0 (the local/injection port).
- Accepts flits from a traffic source or testbench and holds them in one FIFO per VC.
- During the LoadStaging op it drives one buffer word onto slot 0 of the router's in_staging_pl bus.
- It issues only for a VC whose can_inject bit is high, so router input buffer 0 never overflows.

Parameters:
- MAXVC, `maxvc: number of VCs; one FIFO per VC.
- DEPTH, 8: flits per VC FIFO; must be a power of two, at least 2.
- BUF_W, `BufferBitSize (22): width of one buffer word {Full, Vc, flit}.
- CNT_W, 16: width of the injected-flit counter.

Ports:
- clk  in  1  clock, rising-edge for this block; the router acts on the falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  `op_size  router op code broadcast to all routers.
- wr_valid  in  1  source presents a flit.
- wr_data  in  BUF_W  buffer word; Full bit, Vc field, flit with Tail flag.
- wr_ready  out  MAXVC  per-VC ready; a write is accepted when wr_valid=1 and wr_ready[wr_data Vc]=1.
- can_inject  in  MAXVC  from the router; 1 means buffer[0][vc] is empty.
- stage_out  out  BUF_W  drives slot 0 of the router's in_staging_pl.
- inj_count  out  CNT_W  number of flits issued so far.
- idle  out  1  all FIFOs are empty and stage_out.Full=0.
- err  out  1  sticky flag: a write with Vc >= MAXVC was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous): all FIFO pointers and counts=0, stage_out=0, inj_count=0, err=0, round-robin pointer rr=0. Therefore wr_ready=all ones and idle=1.
- Reset asserted mid-operation discards all queued flits; the router is re-initialised separately by the Init op.
- Write, on posedge when wr_valid=1:
  - Full bit=0: the word is ignored.
  - Vc >= MAXVC: the word is dropped and err is set.
  - Otherwise the word is pushed into FIFO[Vc] if count[Vc] < DEPTH; if the FIFO is full the write is not accepted.
- wr_ready[v] = (count[v] != DEPTH), computed from the registered count. There is no same-cycle bypass: a full FIFO refuses a write even if a pop happens on the same edge.
- Issue, on the posedge at which op==`LoadStaging:
  - A VC v is eligible when count[v] > 0 and can_inject[v] = 1.
  - Selection is round-robin starting at rr; the first eligible VC wins.
  - Winner: stage_out <= FIFO head with Full forced to 1 and Vc = v. The FIFO pops, inj_count increments, and rr <= (v+1) mod MAXVC.
  - No eligible VC: stage_out <= 0 and rr is unchanged.
  - At most one flit is issued per LoadStaging cycle.
- Any posedge with op != `LoadStaging: stage_out <= 0.
  - stage_out therefore holds a flit for exactly one cycle, and the router samples it on the falling edge inside that cycle (latency ½ clk).
- A flit written on the same edge as an issue is not visible to that issue decision. It becomes eligible at the next LoadStaging at the earliest.
- A simultaneous push and pop on the same VC is legal; count is unchanged.
- Ordering: strict FIFO per VC, so wormhole order within a VC is preserved. Packets on different VCs may interleave, because the router tracks state per VC.
- can_inject is sampled only at issue edges. It must be stable from Phase1 through LoadStaging, which the router guarantees.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
- inj_count wraps modulo 2^CNT_W without raising an error.
- idle is combinational from the registered state.

Decomposition:
- Use the existing parameters.v macros (`maxvc, `BufferBitSize, `BufferFull, `BufferVc, `FlitTail, `op_size, `LoadStaging). Add `InjDepth=8 there; introduce no other new globals.
- Sub-module vc_fifo (one instance per VC, created by a generate loop):
  - ports: clk, rst_n, push, pop, din, dout (head, combinational), count, full, empty;
  - parameters: W, DEPTH.
- The top level holds the arbiter, the stage register, the counters and err.

Test Plan:
- After reset, write 3 flits to VC1 with can_inject=4'b1111, then 3 LoadStaging cycles -> stage_out carries the 3 flits in order with Full=1 and Vc=1; inj_count=3; idle=1 at the end.
- Write 1 flit each to VC0 and VC2, can_inject=4'b1111 -> first LoadStaging issues VC0, second issues VC2 (rr=3 afterwards).
- VC0 holds 2 flits, can_inject=4'b1110 -> stage_out=0 on LoadStaging and the queue is retained. Set can_inject=4'b1111 -> VC0 issues on the next LoadStaging.
- Write 8 flits to VC3 -> wr_ready[3]=0 and a 9th write is not accepted. One issue -> wr_ready[3]=1 on the next edge.
- Write with Vc=5 when MAXVC=4 -> word dropped, err=1, and err stays 1 until reset.
- Load 4 flits, then pulse rst_n low between posedges -> stage_out, inj_count and err clear immediately and idle=1. Subsequent LoadStaging cycles issue nothing.
